// File: rtl/store_buffer_pkg.sv
// Shared constants and entry layout for the store buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package store_buffer_pkg;

  localparam int SB_AW = 32;
  localparam int SB_DW = 32;

  // One buffered store at the default address/data widths.
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// Store-to-load forwarding: word-address match over occupied entries, youngest wins.
// Latency: purely combinational, same cycle as ld_word_i.
// Backpressure: none; sees registered buffer state only, so same-cycle pushes are invisible.
module store_buffer_fwd #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic [DEPTH-1:0][AW-3:0] addr_i,
  input  logic [DEPTH-1:0][DW-1:0] data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr_i,
  input  logic [$clog2(DEPTH):0]   count_i,
  input  logic [AW-3:0]            ld_word_i,
  output logic                     ld_hit_o,
  output logic [DW-1:0]            ld_data_o
);

  logic [$clog2(DEPTH)-1:0] idx;

  // Walk from oldest to youngest; a later (younger) match overrides an earlier one.
  always_comb begin
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_i + k[$clog2(DEPTH)-1:0];
      if ((k < int'(count_i)) && (addr_i[idx] == ld_word_i)) begin
        ld_hit_o  = 1'b1;
        ld_data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer FIFO between core stores and data memory, with optional load forwarding (STORE_BUFFER_FWD_EN).
// Latency: a push is visible on mem_valid/ld_hit one cycle later; forwarding lookup is combinational.
// Backpressure: st_full stalls the core; mem_ready low holds the oldest entry stable on mem_addr/mem_data.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_en,
  input  logic [AW-1:0]          st_addr,
  input  logic [DW-1:0]          st_data,
  output logic                   st_full,
  input  logic [AW-1:0]          ld_addr,
  output logic                   ld_hit,
  output logic [DW-1:0]          ld_data,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Same layout as sb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        ent_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;

  // Full is taken from the registered count, so a pop cannot make room for a same-cycle push.
  assign st_full   = (cnt_q == CW'(DEPTH));
  assign mem_valid = (cnt_q != '0);
  assign push      = st_en && !st_full;
  assign pop       = mem_valid && mem_ready;
  assign mem_addr  = ent_q[rd_q].addr;
  assign mem_data  = ent_q[rd_q].data;
  assign count     = cnt_q;
  assign overflow  = ovf_q;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q | (st_en & st_full);
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register; reset discards every pending entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entry storage; contents after reset are don't-care since count gates every use.
  always_ff @(posedge clk) begin
    if (push) ent_q[wr_q] <= '{addr: st_addr, data: st_data};
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [DEPTH-1:0][AW-3:0] fwd_addr;
  logic [DEPTH-1:0][DW-1:0] fwd_data;
  logic                     unused_ld_bits;

  // Flatten entries to word addresses for the match network.
  always_comb begin
    fwd_addr = '0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_addr[i] = ent_q[i].addr[AW-1:2];
      fwd_data[i] = ent_q[i].data;
    end
  end

  assign unused_ld_bits = ^ld_addr[1:0];

  store_buffer_fwd #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fwd (
    .addr_i   (fwd_addr),
    .data_i   (fwd_data),
    .rd_ptr_i (rd_q),
    .count_i  (cnt_q),
    .ld_word_i(ld_addr[AW-1:2]),
    .ld_hit_o (ld_hit),
    .ld_data_o(ld_data)
  );
`else
  logic unused_ld_addr;

  assign unused_ld_addr = ^ld_addr;
  assign ld_hit         = 1'b0;
  assign ld_data        = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized traffic against a queue model.
// Latency: model updates at each rising edge; outputs sampled on the falling edge.
// Backpressure: mem_ready driven randomly or per scenario.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_en;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_full;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [2:0]    count;
  logic          overflow;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf;
  ent_t pushed_log[$];
  ent_t drained_log[$];
  bit   rec;
  int   n_chk;
  int   n_err;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .st_en    (st_en),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_full  (st_full),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Compare every output against the queue model and the current inputs.
  task automatic check_outputs();
    bit            e_hit;
    logic [DW-1:0] e_data;
    e_hit  = 1'b0;
    e_data = '0;
`ifdef STORE_BUFFER_FWD_EN
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a[AW-1:2] == ld_addr[AW-1:2]) begin
        e_hit  = 1'b1;
        e_data = mq[i].d;
        break;
      end
    end
`endif
    chk("count", count, mq.size());
    chk("st_full", st_full, mq.size() == DEPTH);
    chk("mem_valid", mem_valid, mq.size() != 0);
    chk("overflow", overflow, m_ovf);
    if (mq.size() != 0) begin
      chk("mem_addr", mem_addr, mq[0].a);
      chk("mem_data", mem_data, mq[0].d);
    end
    chk("ld_hit", ld_hit, e_hit);
    chk("ld_data", ld_data, e_data);
  endtask

  // One clock cycle: drive, check on falling edge, advance model on rising edge.
  task automatic cyc(input bit rst, input bit en, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input bit rdy, input logic [AW-1:0] la);
    bit do_push;
    bit do_pop;
    reset     = rst;
    st_en     = en;
    st_addr   = a;
    st_data   = d;
    mem_ready = rdy;
    ld_addr   = la;
    @(negedge clk);
    check_outputs();
    if (rec && !rst && mem_valid && mem_ready) drained_log.push_back('{a: mem_addr, d: mem_data});
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      do_push = en && (mq.size() < DEPTH);
      do_pop  = rdy && (mq.size() != 0);
      if (en && !do_push) m_ovf = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{a: a, d: d});
        if (rec) pushed_log.push_back('{a: a, d: d});
      end
    end
    #1;
  endtask

  initial begin
    bit            fwd_on;
    logic [AW-1:0] ra;
    n_chk = 0;
    n_err = 0;
    rec   = 1'b0;
    m_ovf = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
    fwd_on = 1'b1;
`else
    fwd_on = 1'b0;
`endif
    reset = 1'b1; st_en = 1'b0; st_addr = '0; st_data = '0; mem_ready = 1'b0; ld_addr = '0;
    @(posedge clk); #1;
    cyc(1, 1, 32'h44, 32'h1, 0, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_full", st_full, 0);
    chk("rst_ovf", overflow, 0);

    // Single push, then stalled drain request.
    cyc(0, 1, 100, 25, 0, 0);
    chk("p1_valid", mem_valid, 1);
    chk("p1_addr", mem_addr, 100);
    chk("p1_data", mem_data, 25);
    chk("p1_count", count, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("stall_addr", mem_addr, 100);
      chk("stall_data", mem_data, 25);
    end
    cyc(0, 0, 0, 0, 1, 0);
    chk("drain_empty", mem_valid, 0);

    // Fill, then overflow.
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h200 + 4 * i, 32'h10 + i, 0, 0);
    chk("full_flag", st_full, 1);
    chk("full_count", count, 4);
    cyc(0, 1, 32'h300, 32'h99, 0, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 4);

    // Full with pop and push in the same cycle: push is dropped.
    cyc(0, 1, 32'h304, 32'h98, 1, 0);
    chk("fullpop_count", count, 3);
    chk("fullpop_full", st_full, 0);
    chk("fullpop_head", mem_addr, 32'h204);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Forwarding: youngest word match, byte offset ignored.
    cyc(0, 1, 96, 7, 0, 96);
    cyc(0, 1, 96, 9, 0, 96);
    cyc(0, 0, 0, 0, 0, 96);
    chk("fwd96_hit", ld_hit, fwd_on);
    chk("fwd96_data", ld_data, fwd_on ? 9 : 0);
    cyc(0, 0, 0, 0, 0, 98);
    chk("fwd98_hit", ld_hit, fwd_on);
    chk("fwd98_data", ld_data, fwd_on ? 9 : 0);
    cyc(0, 0, 0, 0, 0, 104);
    chk("fwd104_hit", ld_hit, 0);
    chk("fwd104_data", ld_data, 0);
    cyc(0, 1, 200, 5, 1, 200);
    cyc(0, 1, 204, 6, 1, 204);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 200);

    // Continuous traffic through pointer wrap with toggling ready.
    rec = 1'b1;
    begin
      int sent;
      int guard;
      sent  = 0;
      guard = 0;
      while ((sent < 10 || mq.size() != 0) && guard < 200) begin
        bit en;
        en = (sent < 10);
        if (en && mq.size() < DEPTH) sent++;
        else en = 1'b0;
        cyc(0, en, 32'h400 + 4 * sent, 32'hA00 + sent, guard[0], 32'h400 + 4 * sent);
        guard++;
      end
      chk("wrap_guard", guard < 200, 1);
    end
    rec = 1'b0;
    chk("wrap_npush", pushed_log.size(), 10);
    chk("wrap_ndrain", drained_log.size(), 10);
    for (int i = 0; i < 10 && i < pushed_log.size() && i < drained_log.size(); i++) begin
      chk("wrap_addr", drained_log[i].a, pushed_log[i].a);
      chk("wrap_data", drained_log[i].d, pushed_log[i].d);
    end

    // Reset with three pending entries and overflow set.
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'h500 + 4 * i, i, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("prerst_count", count, 3);
    chk("prerst_ovf", overflow, 1);
    cyc(1, 1, 32'h500, 32'h77, 0, 32'h500);
    chk("midrst_count", count, 0);
    chk("midrst_valid", mem_valid, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_hit", ld_hit, 0);

    // Randomized traffic over a small address window to provoke matches.
    for (int i = 0; i < 400; i++) begin
      ra = 32'h60 + $urandom_range(0, 15);
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, 32'h60 + $urandom_range(0, 15),
          $urandom, $urandom_range(0, 1) == 1, ra);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, >= 2).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 clk  input  1  rising-edge clock; single clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 st_en  input  1  core store request (core MemWrite).
REQ-007 st_addr  input  AW  core store address (core DataAddr).
REQ-008 st_data  input  DW  core store data (core WriteData).
REQ-009 st_full  output  1  buffer full; core must stall stores.
REQ-010 ld_addr  input  AW  core load address for forwarding lookup.
REQ-011 ld_hit  output  1  ld_addr matches a buffered store.
REQ-012 ld_data  output  DW  forwarded data, youngest matching entry.
REQ-013 mem_valid  output  1  drain request to data memory.
REQ-014 mem_ready  input  1  data memory accepts the drain request.
REQ-015 mem_addr  output  AW  address of oldest entry.
REQ-016 mem_data  output  DW  data of oldest entry.
REQ-017 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-018 overflow  output  1  sticky flag: store attempted while full.

Function
REQ-019 SHALL be a FIFO: push = st_en && !st_full; pop = mem_valid && mem_ready.
REQ-020 SHALL register pushed entries; mem_valid rises exactly 1 cycle after a push into an empty buffer (no same-cycle bypass).
REQ-021 mem_valid SHALL equal (count != 0); mem_addr/mem_data SHALL hold stable while mem_valid && !mem_ready.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-023 st_full SHALL equal (count == DEPTH), computed from the registered count; a push while full is dropped even if a pop occurs that cycle.
REQ-024 A dropped push (st_en && st_full) SHALL set overflow; overflow clears only on reset.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-026 Forwarding SHALL compare ld_addr[AW-1:2] with entry addr[AW-1:2] over occupied entries only, select the youngest match, and be combinational (same cycle).
REQ-027 An entry popped this cycle SHALL still be forwardable this cycle; an entry pushed this cycle SHALL NOT be forwarded until the next cycle.
REQ-028 With no match, ld_hit SHALL be 0 and ld_data SHALL be 0.

Reset
REQ-029 On reset high at a clock edge: pointers, count = 0; mem_valid = 0; st_full = 0; overflow = 0; ld_hit = 0; entry contents are don't-care.
REQ-030 Reset mid-operation SHALL discard all pending entries without issuing further mem_valid; a push in the reset cycle is ignored.

Configuration
REQ-031 Macro STORE_BUFFER_FWD_EN defined: forwarding logic per REQ-026..028 is compiled in.
REQ-032 Macro STORE_BUFFER_FWD_EN undefined: ld_hit tied 0, ld_data tied 0, no comparators synthesized; ld_addr unused.

Structure
REQ-033 Shared package SHALL hold the default AW/DW constants and a packed entry typedef {addr, data}.
REQ-034 Forwarding match/priority logic SHALL be one sub-module, store_buffer_fwd, instantiated only under STORE_BUFFER_FWD_EN.

Verification
REQ-035 Push addr 100 data 25 with mem_ready=0 -> next cycle mem_valid=1, mem_addr=100, mem_data=25, count=1; held stable over 3 stalled cycles.
REQ-036 Push 4 stores with mem_ready=0 -> st_full=1, count=4; 5th st_en -> dropped, overflow=1, count stays 4.
REQ-037 Full buffer, st_en=1 with mem_ready=1 same cycle -> one pop, push dropped, count=3, st_full=0 next cycle.
REQ-038 Push (96,7) then (96,9), ld_addr=96 and ld_addr=98 -> ld_hit=1, ld_data=9 in both cases (word match); ld_addr=104 -> ld_hit=0, ld_data=0.
REQ-039 Push/pop continuously across 10 stores with mem_ready toggling -> drained sequence equals pushed sequence through pointer wrap.
REQ-040 Reset with count=3 -> next cycle count=0, mem_valid=0, overflow=0, ld_hit=0.
